// File: rtl/timer_ctrl_if.sv
// CPU-side register bus for the countdown timer: control store, status load, irq.
interface timer_ctrl_if;
  logic        TIMER_ctrl_we;
  logic [31:0] TIMER_ctrl_wdata;
  logic [31:0] TIMER_done_rdata;
  logic        irq;

  // Decoder / CPU side drives the control strobe and reads status.
  modport master (
    output TIMER_ctrl_we,
    output TIMER_ctrl_wdata,
    input  TIMER_done_rdata,
    input  irq
  );

  // Timer side consumes the control strobe and presents status.
  modport slave (
    input  TIMER_ctrl_we,
    input  TIMER_ctrl_wdata,
    output TIMER_done_rdata,
    output irq
  );
endinterface

// File: rtl/timer_ctrl.sv
// Memory-mapped countdown timer: a control write loads a tick count and
// optional periodic mode; a prescaler turns clk cycles into ticks; expiry
// raises sticky done (and overrun on a repeat expiry) plus a one-cycle irq.
module timer_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 31
) (
  input  logic        clk,
  input  logic        reset,
  timer_ctrl_if.slave bus
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [PRESC_W-1:0] prescaler_q, prescaler_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   reload_q,    reload_d;
  logic               periodic_q,  periodic_d;
  logic               done_q,      done_d;
  logic               overrun_q,   overrun_d;
  logic               irq_q,       irq_d;

  logic [CNT_W-1:0]   wr_count;
  logic               tick;
  logic               busy;

  assign wr_count = bus.TIMER_ctrl_wdata[CNT_W-1:0];
  assign busy     = (state_q == ST_RUN);

  // Next-state logic: a control write always takes priority over counting,
  // so a write landing on an expiry edge suppresses that expiry entirely.
  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    periodic_d  = periodic_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    irq_d       = 1'b0;
    tick        = 1'b0;

    if (bus.TIMER_ctrl_we) begin
      done_d      = 1'b0;
      overrun_d   = 1'b0;
      prescaler_d = '0;
      if (wr_count == '0) begin
        state_d     = ST_IDLE;
        remaining_d = '0;
      end else begin
        state_d     = ST_RUN;
        remaining_d = wr_count;
        reload_d    = wr_count;
        periodic_d  = bus.TIMER_ctrl_wdata[31];
      end
    end else if (state_q == ST_RUN) begin
      if (prescaler_q == PRESC_MAX) begin
        prescaler_d = '0;
        tick        = 1'b1;
      end else begin
        prescaler_d = prescaler_q + PRESC_W'(1);
      end

      if (tick) begin
        if (remaining_q > CNT_ONE) begin
          remaining_d = remaining_q - CNT_ONE;
        end else begin
          // Expiry: a second expiry before software clears done is an overrun.
          irq_d     = 1'b1;
          overrun_d = overrun_q | done_q;
          done_d    = 1'b1;
          if (periodic_q) begin
            remaining_d = reload_q;
          end else begin
            remaining_d = '0;
            state_d     = ST_EXPIRED;
          end
        end
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      prescaler_q <= '0;
      remaining_q <= '0;
      reload_q    <= '0;
      periodic_q  <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      periodic_q  <= periodic_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.TIMER_done_rdata = {29'd0, overrun_q, busy, done_q};
  assign bus.irq              = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl (TICK_DIV=4): directed scenarios followed by random
// control writes, checked every cycle against an expiry-time reference model.
module tb_timer_ctrl;

  localparam int TD = 4;

  logic clk;
  logic reset;

  timer_ctrl_if bus ();

  timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int irq_seen   = 0;

  // Reference model: tracks the absolute edge number of the next expiry.
  bit      m_run, m_per, m_done, m_ovr, m_irq;
  longint  m_next, m_period;
  logic [31:0] exp_status;

  task automatic model_reset();
    m_run = 0; m_per = 0; m_done = 0; m_ovr = 0; m_irq = 0;
    m_next = 0; m_period = 0;
    exp_status = 32'h0;
  endtask

  task automatic model_edge(input logic we, input logic [31:0] wd);
    longint n;
    n = longint'(wd[30:0]);
    m_irq = 0;
    if (we) begin
      m_done = 0;
      m_ovr  = 0;
      if (n == 0) begin
        m_run = 0;
      end else begin
        m_run    = 1;
        m_per    = wd[31];
        m_period = n * TD;
        m_next   = longint'(cyc) + m_period;
      end
    end else if (m_run && longint'(cyc) == m_next) begin
      m_irq  = 1;
      m_ovr  = m_ovr | m_done;
      m_done = 1;
      if (m_per) m_next = m_next + m_period;
      else       m_run  = 0;
    end
    exp_status = {29'd0, m_ovr, m_run, m_done};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=0x%08h expected=0x%08h", tag, cyc, obs, expv);
    end
  endtask

  // One clock: drive inputs, advance model on the edge, check #1 after.
  task automatic step(input logic we, input logic [31:0] wd);
    bus.TIMER_ctrl_we    = we;
    bus.TIMER_ctrl_wdata = wd;
    @(posedge clk);
    cyc++;
    if (reset) model_edge(we, wd);
    else       model_reset();
    #1;
    if (we) $display("cyc=%0d write 0x%08h status=0x%08h irq=%0b",
                     cyc, wd, bus.TIMER_done_rdata, bus.irq);
    check("status", bus.TIMER_done_rdata, exp_status);
    check("irq", {31'd0, bus.irq}, {31'd0, m_irq});
    if (bus.irq) irq_seen++;
    bus.TIMER_ctrl_we    = 1'b0;
    bus.TIMER_ctrl_wdata = 32'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  initial begin
    int base;
    int n;
    int r;
    bit per;
    bus.TIMER_ctrl_we    = 1'b0;
    bus.TIMER_ctrl_wdata = 32'h0;
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_status", bus.TIMER_done_rdata, 32'h0);
    check("reset_irq", {31'd0, bus.irq}, 32'h0);
    idle(2);
    reset = 1'b1;

    // 1. idle after reset
    idle(20);
    check("s1_irq_count", irq_seen, 0);

    // 2. one-shot N=3
    base = irq_seen;
    step(1'b1, 32'h0000_0003);
    idle(11);
    check("s2_busy", bus.TIMER_done_rdata, 32'h2);
    idle(1);
    check("s2_done", bus.TIMER_done_rdata, 32'h1);
    check("s2_irq", {31'd0, bus.irq}, 32'h1);
    idle(50);
    check("s2_hold", bus.TIMER_done_rdata, 32'h1);
    check("s2_irq_count", irq_seen - base, 1);

    // 3. periodic N=2, overrun on second expiry
    base = irq_seen;
    step(1'b1, 32'h8000_0002);
    idle(8);
    check("s3_first", bus.TIMER_done_rdata, 32'h3);
    idle(8);
    check("s3_overrun", bus.TIMER_done_rdata, 32'h7);
    idle(8);
    check("s3_irq_count", irq_seen - base, 3);
    step(1'b1, 32'h0);
    check("s3_stop", bus.TIMER_done_rdata, 32'h0);
    idle(30);
    check("s3_no_more_irq", irq_seen - base, 3);

    // 4. restart mid-run
    base = irq_seen;
    step(1'b1, 32'h5);
    idle(9);
    step(1'b1, 32'h2);
    idle(7);
    check("s4_not_yet", bus.TIMER_done_rdata, 32'h2);
    idle(1);
    check("s4_done", bus.TIMER_done_rdata, 32'h1);
    idle(20);
    check("s4_irq_count", irq_seen - base, 1);

    // 5. write colliding with expiry edge
    base = irq_seen;
    step(1'b1, 32'h1);
    idle(3);
    step(1'b1, 32'h1);
    check("s5_collide_irq", {31'd0, bus.irq}, 32'h0);
    check("s5_collide_status", bus.TIMER_done_rdata, 32'h2);
    idle(4);
    check("s5_second_irq", {31'd0, bus.irq}, 32'h1);
    idle(5);

    // 6. asynchronous reset mid-run
    base = irq_seen;
    step(1'b1, 32'd10);
    idle(14);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("s6_async_status", bus.TIMER_done_rdata, 32'h0);
    check("s6_async_irq", {31'd0, bus.irq}, 32'h0);
    idle(2);
    reset = 1'b1;
    idle(40);
    check("s6_irq_count", irq_seen - base, 0);

    // Random control writes with random gaps, including N=0 and max N.
    for (int t = 0; t < 40; t++) begin
      r   = int'($urandom_range(0, 9));
      per = 1'($urandom_range(0, 1));
      if (r == 0)      n = 0;
      else if (r == 9) n = 32'h7FFF_FFFF;
      else             n = int'($urandom_range(1, 6));
      step(1'b1, {per, n[30:0]});
      idle(int'($urandom_range(0, 40)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Memory-mapped countdown timer controller behind the peripheral decoder's TIMER slot.
- A CPU store to the timer control address (0x18) arrives as TIMER_ctrl_we/TIMER_ctrl_wdata and configures the timer.
- The timer then runs for a programmed number of prescaled ticks.
- A CPU load from the timer status address (0x1C) returns TIMER_done_rdata: status flags for software polling.
- A one-cycle irq pulse on expiry is available for future interrupt wiring.

Parameters:
TICK_DIV, 100000, clk cycles per timer tick (1 ms at 100 MHz); legal range >= 1; TICK_DIV=1 must work.
CNT_W, 31, width of the tick down-counter; fixed by control-word layout; do not change.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
TIMER_ctrl_we  input  1  one-cycle write strobe from decoder
TIMER_ctrl_wdata  input  32  control word: [31]=periodic, [30:0]=tick count N
TIMER_done_rdata  output  32  status: [0]=done, [1]=busy, [2]=overrun, [31:3]=0
irq  output  1  one-cycle pulse on each expiry

Behaviour:
- Reset (reset=0, async): state=IDLE; prescaler=0; remaining=0; periodic=0; done=0; overrun=0; irq=0; TIMER_done_rdata=0. Release is synchronous to clk.
- States: IDLE (busy=0), RUN (busy=1), EXPIRED (busy=0, done=1). busy = (state==RUN), combinational from state.
- Write, N==0 (any state): go to IDLE; clear done and overrun; prescaler=0; remaining=0.
- Write, N!=0 (any state, including RUN): restart.
  - reload=N, remaining=N, periodic=wdata[31], prescaler=0.
  - Clear done and overrun; go to RUN.
- RUN, prescaler:
  - If prescaler==TICK_DIV-1: prescaler<=0 and tick=1.
  - Else: prescaler<=prescaler+1, tick=0.
- RUN, on tick with remaining>1: remaining<=remaining-1.
- RUN, on tick with remaining==1 (expiry):
  - irq=1 for exactly that cycle (registered; visible the cycle after the expiring edge).
  - If done already 1: set overrun. Then set done.
  - periodic=1: remaining<=reload; stay in RUN.
  - periodic=0: remaining<=0; go to EXPIRED.
- Latency: write latched at edge E0 with count N. done and irq are visible after edge E0 + N*TICK_DIV; the next periodic expiry follows N*TICK_DIV cycles later.
- done and overrun are sticky. Only a control write or reset clears them; status reads have no side effects.
- EXPIRED: hold until a write; no counting.
- Simultaneous write and expiry in the same cycle: the write wins. The write effect is applied, no irq, done/overrun cleared.
- Width rules:
  - remaining and reload are 31-bit unsigned; max N = 2^31-1, no wrap.
  - prescaler width is $clog2(TICK_DIV); minimum 1 bit.
- TIMER_done_rdata is a direct combinational mapping of registered flags; no read latency added.
- Reset asserted mid-RUN aborts immediately to reset values, and no irq is emitted.

Test Plan:
All scenarios use TICK_DIV=4.
1. Reset, then idle 20 cycles -> TIMER_done_rdata=0x0, irq=0 throughout.
2. One-shot: write 0x0000_0003 at edge E0.
   - Status reads 0x2 (busy) from E0+1 through edge E0+12.
   - After edge E0+12: status=0x1 and a single-cycle irq.
   - Status stays 0x1 for 50 more cycles.
3. Periodic: write 0x8000_0002.
   - irq pulses after E0+8, E0+16 and E0+24.
   - After the first pulse: status=0x3. After the second pulse: status=0x7 (overrun).
   - Then write 0x0 -> status=0x0, no further irq.
4. Restart mid-run: write N=5, then write N=2 at E0+10 -> expiry after edge E0+18 (not E0+20); exactly one irq.
5. Collision: write N=1 at E0; a second write of N=1 lands on edge E0+4 (the expiry edge) -> no irq at E0+4; done=0; next expiry after E0+8.
6. Reset mid-run: write N=10, assert reset at E0+15 for 2 cycles -> status=0 immediately (async). No irq after release, even past E0+40.
